tick_sequencer: RTL

//  Programmable controller that sequences the display counter's enable input.

---
 rtl/tick_sequencer_if.sv | 23 ++
 rtl/tick_sequencer.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/tick_sequencer_if.sv
// rtl/tick_sequencer_if.sv - control, table-programming and status bundle for tick_sequencer
interface tick_sequencer_if;
    logic       i_start;
    logic       i_abort;
    logic       i_prog_we;
    logic [1:0] i_prog_addr;
    logic [1:0] i_prog_speed;
    logic [3:0] i_prog_pulses;
    logic       o_enable;
    logic [1:0] o_step;
    logic       o_busy;
    logic       o_done;

    modport master (
        output i_start, i_abort, i_prog_we, i_prog_addr, i_prog_speed, i_prog_pulses,
        input  o_enable, o_step, o_busy, o_done
    );

    modport slave (
        input  i_start, i_abort, i_prog_we, i_prog_addr, i_prog_speed, i_prog_pulses,
        output o_enable, o_step, o_busy, o_done
    );
endinterface

// File: rtl/tick_sequencer.sv
// rtl/tick_sequencer.sv - scripted speed-profile sequencer driving the display counter enable
module tick_sequencer #(
    parameter int CLOCK_FREQUENCY = 50000000,
    parameter int NUM_STEPS       = 4
) (
    input  logic            i_clock_in,
    input  logic            i_reset,
    tick_sequencer_if.slave bus
);

    // Wide enough that the 4-second period never truncates.
    localparam int         CW          = $clog2(4 * CLOCK_FREQUENCY + 1);
    localparam logic [2:0] NUM_STEPS_W = 3'(NUM_STEPS);
    localparam logic [1:0] LAST_STEP   = 2'(NUM_STEPS - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

    state_t          r_state;
    logic [1:0]      r_step;
    logic [CW-1:0]   r_cnt;
    logic [3:0]      r_pulse_cnt;
    logic            r_enable;
    logic [1:0]      r_speed  [4];
    logic [3:0]      r_pulses [4];

    state_t          w_state_next;
    logic [1:0]      w_step_next;
    logic [CW-1:0]   w_cnt_next;
    logic [3:0]      w_pulse_next;
    logic            w_enable_next;
    logic [CW-1:0]   w_reload;
    logic [3:0]      w_cur_pulses;
    logic            w_last;

    // Down-counter reload value is period-1 for the speed code.
    function automatic logic [CW-1:0] f_reload(input logic [1:0] speed);
        case (speed)
            2'b00:   f_reload = '0;
            2'b01:   f_reload = CW'(CLOCK_FREQUENCY - 1);
            2'b10:   f_reload = CW'(2 * CLOCK_FREQUENCY - 1);
            default: f_reload = CW'(4 * CLOCK_FREQUENCY - 1);
        endcase
    endfunction

    assign w_reload     = f_reload(r_speed[r_step]);
    assign w_cur_pulses = r_pulses[r_step];
    assign w_last       = (r_step == LAST_STEP);

    // Program table: writable only while no program is executing.
    always_ff @(posedge i_clock_in) begin
        if (i_reset) begin
            for (int i = 0; i < 4; i++) begin
                r_speed[i]  <= 2'b00;
                r_pulses[i] <= 4'd0;
            end
        end else if (bus.i_prog_we && (r_state == S_IDLE || r_state == S_DONE) &&
                     ({1'b0, bus.i_prog_addr} < NUM_STEPS_W)) begin
            r_speed[bus.i_prog_addr]  <= bus.i_prog_speed;
            r_pulses[bus.i_prog_addr] <= bus.i_prog_pulses;
        end
    end

    // State, step index, counters and the registered Enable pulse.
    always_ff @(posedge i_clock_in) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_step      <= 2'd0;
            r_cnt       <= '0;
            r_pulse_cnt <= 4'd0;
            r_enable    <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_step      <= w_step_next;
            r_cnt       <= w_cnt_next;
            r_pulse_cnt <= w_pulse_next;
            r_enable    <= w_enable_next;
        end
    end

    // Next-state logic; Abort overrides whatever the state would otherwise do.
    always_comb begin
        w_state_next  = r_state;
        w_step_next   = r_step;
        w_cnt_next    = r_cnt;
        w_pulse_next  = r_pulse_cnt;
        w_enable_next = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_step_next  = 2'd0;
                w_cnt_next   = '0;
                w_pulse_next = 4'd0;
                if (bus.i_start) w_state_next = S_LOAD;
            end
            S_LOAD: begin
                if (w_cur_pulses == 4'd0) begin
                    // Zero-pulse entry: move straight on to the next step.
                    if (w_last) w_state_next = S_DONE;
                    else        w_step_next  = r_step + 2'd1;
                end else begin
                    w_cnt_next   = w_reload;
                    w_pulse_next = w_cur_pulses;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (r_cnt == '0) begin
                    w_enable_next = 1'b1;
                    w_pulse_next  = r_pulse_cnt - 4'd1;
                    w_cnt_next    = w_reload;
                    if (r_pulse_cnt == 4'd1) begin
                        if (w_last) begin
                            w_state_next = S_DONE;
                        end else begin
                            w_state_next = S_LOAD;
                            w_step_next  = r_step + 2'd1;
                        end
                    end
                end else begin
                    w_cnt_next = r_cnt - CW'(1);
                end
            end
            S_DONE: begin
                if (bus.i_start) begin
                    w_state_next = S_LOAD;
                    w_step_next  = 2'd0;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
        if (bus.i_abort && r_state != S_IDLE) begin
            w_state_next  = S_IDLE;
            w_step_next   = 2'd0;
            w_cnt_next    = '0;
            w_pulse_next  = 4'd0;
            w_enable_next = 1'b0;
        end
    end

    assign bus.o_enable = r_enable;
    assign bus.o_step   = r_step;
    assign bus.o_busy   = (r_state == S_LOAD) || (r_state == S_RUN);
    assign bus.o_done   = (r_state == S_DONE);

endmodule
